uart_tx_fifo: RTL and testbench

- Buffered UART transmitter that consumes the console byte writes produced by the dual-issue CPU core's memory-access path.
- Two write ports, one per issue slot, so both slots can store to the UART address in the same cycle without losing a byte.
- Bytes enter a circular FIFO in program order (slot 1 before slot 2) and are serialized as 8N1 frames on uart_tx.
- Sits between the EX/MA store-address decode and the board TX pin; replaces the single-port direct UART hookup.

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Dual-port byte FIFO feeding an 8N1 UART serializer; slot 1 is always queued ahead of slot 2.
// Writes into a full FIFO are dropped and latch the sticky overflow flag.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr1,
  input  logic [7:0]            dat1,
  input  logic                  wr2,
  input  logic [7:0]            dat2,
  input  logic                  ovf_clr,
  output logic                  uart_tx,
  output logic                  busy,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int BCW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [DEPTH];

  logic [CW-1:0]         free;
  logic                  acc1, acc2, drop, pop, bit_end;
  logic [DEPTH_LOG2-1:0] wa2;

  // Free space is taken from the pre-edge count, so a same-edge pop never frees a slot.
  always_comb begin
    free   = DEPTH_C - count_q;
    acc1   = wr1 && (free != '0);
    acc2   = wr2 && (free > {{DEPTH_LOG2{1'b0}}, acc1});
    drop   = (wr1 && !acc1) || (wr2 && !acc2);
    wa2    = wptr_q + DEPTH_LOG2'(acc1);
    wptr_d = wptr_q + DEPTH_LOG2'(acc1) + DEPTH_LOG2'(acc2);
    ovf_d  = drop | (ovf_q & ~ovf_clr);
  end

  always_comb begin
    state_d   = state_q;
    bit_end   = (bit_cnt_q == BIT_LAST);
    bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rptr_d    = rptr_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d      = shift_q[1];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (bit_end) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
    if (pop) begin
      shift_d = mem_q[rptr_q];
      rptr_d  = rptr_q + 1'b1;
    end
    count_d = count_q + CW'(acc1) + CW'(acc2) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc1) mem_q[wptr_q] <= dat1;
    if (acc2) mem_q[wa2]    <= dat2;
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != IDLE);
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a scoreboard of accepted bytes is checked against frames decoded off uart_tx.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr1 = 1'b0, wr2 = 1'b0, ovf_clr = 1'b0;
  logic [7:0] dat1 = 8'h00, dat2 = 8'h00;
  logic       uart_tx, busy, full, empty, overflow;
  logic [4:0] count;

  logic [7:0] sb [$];
  int         mdl_count = 0;
  logic       mdl_ovf = 1'b0;
  int         checks = 0, errors = 0;
  int         mon_cnt = -1;
  logic [7:0] mon_byte = 8'h00, last_rx = 8'h00, exp_b;
  logic       saw_55 = 1'b0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .wr1(wr1), .dat1(dat1), .wr2(wr2), .dat2(dat2),
    .ovf_clr(ovf_clr), .uart_tx(uart_tx), .busy(busy), .full(full),
    .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Frame decoder: a start bit seen at a negedge marks the pop at the preceding posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mon_cnt = -1;
      end else begin
        if (mon_cnt < 0) begin
          if (uart_tx === 1'b0) begin
            mon_cnt = 0;
            mdl_count--;
          end
        end else begin
          mon_cnt++;
        end
        if (mon_cnt == 2) begin
          checks++;
          if (uart_tx !== 1'b0) begin
            errors++;
            $display("FAIL start_bit: got %b want 0", uart_tx);
          end
        end
        if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
          mon_byte = {uart_tx, mon_byte[7:1]};
        if (mon_cnt == 38) begin
          checks++;
          if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL stop_bit: got %b want 1", uart_tx);
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got %h want none", mon_byte);
          end else begin
            exp_b = sb.pop_front();
            if (mon_byte !== exp_b) begin
              errors++;
              $display("FAIL frame_data: got %h want %h", mon_byte, exp_b);
            end
          end
          last_rx = mon_byte;
          if (mon_byte == 8'h55) saw_55 = 1'b1;
          mon_cnt = -1;
        end
      end
    end
  end

  // One write cycle; the model decides acceptance from its own occupancy.
  task automatic drive(input logic w1, input logic [7:0] d1, input logic w2,
                       input logic [7:0] d2, input logic clr);
    int  free;
    logic a1, a2;
    @(negedge clk); #1;
    free = DEPTH - mdl_count;
    a1 = w1 && (free >= 1);
    a2 = w2 && (free >= (a1 ? 2 : 1));
    wr1 = w1; dat1 = d1; wr2 = w2; dat2 = d2; ovf_clr = clr;
    if (a1) sb.push_back(d1);
    if (a2) sb.push_back(d2);
    mdl_count += int'(a1) + int'(a2);
    if ((w1 && !a1) || (w2 && !a2)) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    @(posedge clk); #1;
    wr1 = 1'b0; wr2 = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic wait_drain(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy && mon_cnt < 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({uart_tx, busy, full, empty, count, overflow} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got tx=%b busy=%b full=%b empty=%b count=%0d ovf=%b want 1 0 0 1 0 0",
               uart_tx, busy, full, empty, count, overflow);
    end
  endtask

  task automatic test_single();
    int  n;
    bit  ok;
    drive(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd1 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_enq: got count=%0d tx=%b want 1 1", count, uart_tx);
    end
    @(negedge clk); #1;
    checks++;
    if (uart_tx !== 1'b0 || busy !== 1'b1 || empty !== 1'b1 || count !== 5'(mdl_count)) begin
      errors++;
      $display("FAIL single_start: got tx=%b busy=%b empty=%b count=%0d want 0 1 1 %0d",
               uart_tx, busy, empty, count, mdl_count);
    end
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n !== 40) begin
      errors++;
      $display("FAIL single_busy_len: got %0d want 40", n);
    end
    wait_drain(200, ok);
    checks++;
    if (!ok || last_rx !== 8'h41 || uart_tx !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: got ok=%b last=%h tx=%b want 1 41 1", ok, last_rx, uart_tx);
    end
  endtask

  task automatic test_dual();
    int n;
    bit ok;
    drive(1'b1, 8'h48, 1'b1, 8'h69, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL dual_count2: got %0d want 2", count);
    end
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd1 || uart_tx !== 1'b0) begin
      errors++;
      $display("FAIL dual_count1: got count=%0d tx=%b want 1 0", count, uart_tx);
    end
    n = 0;
    while (busy && n < 200) begin
      if (n == 40) begin
        checks++;
        if (count !== 5'd0 || uart_tx !== 1'b0) begin
          errors++;
          $display("FAIL dual_second_pop: got count=%0d tx=%b want 0 0", count, uart_tx);
        end
      end
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n !== 80) begin
      errors++;
      $display("FAIL dual_busy_len: got %0d want 80", n);
    end
    wait_drain(200, ok);
    checks++;
    if (!ok || last_rx !== 8'h69) begin
      errors++;
      $display("FAIL dual_drain: got ok=%b last=%h want 1 69", ok, last_rx);
    end
  endtask

  task automatic test_slot2();
    bit ok;
    drive(1'b0, 8'h00, 1'b1, 8'h0A, 1'b0);
    wait_drain(200, ok);
    checks++;
    if (!ok || last_rx !== 8'h0A || overflow !== 1'b0) begin
      errors++;
      $display("FAIL slot2_only: got ok=%b last=%h ovf=%b want 1 0a 0", ok, last_rx, overflow);
    end
  endtask

  task automatic test_full();
    int  k;
    bit  ok;
    k = 0;
    while (mdl_count < DEPTH && k < 40) begin
      if (DEPTH - mdl_count >= 2) drive(1'b1, 8'(8'h10 + 2*k), 1'b1, 8'(8'h11 + 2*k), 1'b0);
      else                       drive(1'b1, 8'(8'h10 + 2*k), 1'b0, 8'h00, 1'b0);
      k++;
    end
    @(negedge clk); #1;
    checks++;
    if (full !== 1'b1 || count !== 5'(mdl_count) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: got full=%b count=%0d ovf=%b want 1 %0d 0", full, count, overflow, mdl_count);
    end
    drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b1 || overflow !== mdl_ovf) begin
      errors++;
      $display("FAIL full_drop: got count=%0d ovf=%b want 16 1", count, overflow);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    drive(1'b1, 8'h56, 1'b0, 8'h00, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (overflow !== 1'b1 || overflow !== mdl_ovf) begin
      errors++;
      $display("FAIL ovf_set_wins: got %b want 1", overflow);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    k = 0;
    while (mdl_count != DEPTH - 1 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (count !== 5'd15 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL one_free_pre: got count=%0d ovf=%b want 15 0", count, overflow);
    end
    drive(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b0);
    @(negedge clk); #1;
    checks++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL one_free: got count=%0d full=%b ovf=%b want 16 1 1", count, full, overflow);
    end
    wait_drain(2000, ok);
    checks++;
    if (!ok || last_rx !== 8'hAA || saw_55 !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got ok=%b last=%h saw55=%b want 1 aa 0", ok, last_rx, saw_55);
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    int  k, lows;
    bit  ok;
    drive(1'b1, 8'hC3, 1'b1, 8'h3C, 1'b0);
    drive(1'b1, 8'h96, 1'b1, 8'h69, 1'b0);
    k = 0;
    while (mon_cnt != 17 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (mon_cnt != 17 || count !== 5'd3) begin
      errors++;
      $display("FAIL mid_setup: got phase=%0d count=%0d want 17 3", mon_cnt, count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got tx=%b busy=%b count=%0d empty=%b want 1 0 0 1", uart_tx, busy, count, empty);
    end
    sb.delete();
    mdl_count = 0;
    mdl_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d active cycles want 0", lows);
    end
    drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    wait_drain(200, ok);
    checks++;
    if (!ok || last_rx !== 8'h5A) begin
      errors++;
      $display("FAIL post_reset_frame: got ok=%b last=%h want 1 5a", ok, last_rx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_dual();
    test_slot2();
    test_full();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
